audio_sample_feeder: RTL
========================

Name: audio_sample_feeder

Overview:
- Upstream producer for the I2S transmitter: fetches 8-bit unsigned PCM samples from the sample ROM and presents one 32-bit frame word, aligned to LRCLK.
- Runs on the 50 MHz system clock and synchronises the codec's LRCLK internally.
- Output word is updated only at the start of a frame, so the transmitter sees a stable value for a full LRCLK period.
- Replaces the free-running ROM counter with play/stop/loop control.

Parameters:
- ADDR_W, 16, ROM address width.
- SAMPLE_LEN, 16'd44000, number of samples in the clip; last address is SAMPLE_LEN-1.

Ports:
- Clk  input  1  50 MHz system clock.
- Reset_n  input  1  synchronous, active-low reset.
- LRCLK  input  1  codec word clock, asynchronous to Clk.
- play  input  1  level; high = playback requested.
- loop  input  1  level; high = wrap to address 0 at end of clip.
- volume  input  3  attenuation; 0 = full scale, each step = -6 dB (arithmetic right shift).
- rom_addr  output  ADDR_W  ROM read address.
- rom_data  input  8  ROM read data, valid exactly 1 Clk after rom_addr changes.
- sample_out  output  32  frame word to the I2S transmitter.
- sample_strobe  output  1  one-cycle pulse when sample_out updates.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when a non-looping clip ends.

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - sample_out=0, rom_addr=0, sample_strobe=0, busy=0, done=0.
  - Synchroniser flops cleared; state=IDLE.
  - Applies mid-operation with no completion of the current fetch.
- LRCLK synchronisation:
  - 2-flop synchroniser followed by a history flop.
  - frame_start = (sync==0 && hist==1), i.e. a falling LRCLK edge, which starts the left channel.
  - frame_start is asserted 3 Clk after the raw edge, ±1 cycle of metastability.
- Conversion:
  - s8 = rom_data ^ 8'h80 (signed, midpoint 0x80 maps to 0).
  - s24 = {s8,16'h0} >>> volume.
  - sample_out = {1'b0, s24, 7'b0}, which is MSB-justified with a one-bit I2S delay.
- States: IDLE, FETCH, WAIT, LOAD.
  - IDLE:
    - sample_out holds 0 (silence).
    - On frame_start with play=1: rom_addr <= 0, busy <= 1, go to FETCH.
    - play is sampled only on frame_start.
  - FETCH: hold rom_addr for 1 cycle; go to WAIT.
  - WAIT: capture rom_data and compute s24; go to LOAD.
  - LOAD: hold the prepared word. On the next frame_start:
    - sample_out <= prepared word, sample_strobe=1 for that cycle.
    - If play=0: sample_out <= 0 instead, busy <= 0, go to IDLE. No done pulse.
    - Else if rom_addr==SAMPLE_LEN-1 and loop=1: rom_addr <= 0, go to FETCH.
    - Else if rom_addr==SAMPLE_LEN-1 and loop=0: done=1 for that cycle, busy <= 0, go to IDLE. The last sample is still output this frame; the next frame outputs 0.
    - Else: rom_addr <= rom_addr+1, go to FETCH.
- Latency:
  - The first sample after start reaches sample_out on the second frame_start after play is seen. The first frame after start outputs 0.
  - Each subsequent sample follows one frame later.
  - Prefetch (FETCH→WAIT→LOAD) completes within 3 Clk, far less than one LRCLK period.
- Simultaneous events:
  - frame_start while in FETCH/WAIT cannot occur in legal operation (LRCLK period ≥ 256 Clk).
  - If it does occur, the event is ignored and the previous sample_out is held.
- Changes to volume or loop take effect on the next prefetch or end-of-clip decision; there is no mid-frame glitch on sample_out.
- rom_addr wraps only via loop; it never exceeds SAMPLE_LEN-1.

Test Plan:
- Reset: drive Reset_n=0 for 2 Clk with LRCLK toggling → sample_out=0, rom_addr=0, busy=0; no strobe while play=0.
- Start timing: play=1 with ROM[0]=0xFF, volume=0; LRCLK period 1040 Clk.
  - First frame_start → busy=1, sample_out stays 0.
  - Second frame_start → sample_out=0x3F800000, 1-cycle strobe, within 3–4 Clk of the raw LRCLK fall.
- Conversion/volume:
  - ROM=0x80 → sample_out=0.
  - ROM=0x00, volume=0 → sample_out=0x40000000.
  - ROM=0xFF, volume=2 → s24=0x1FC000, sample_out=0x0FE00000.
- End, no loop: SAMPLE_LEN=4, loop=0 → 4 samples emitted; done pulses with the 4th; the next frame outputs 0; busy=0; rom_addr stays 3.
- End, loop: SAMPLE_LEN=4, loop=1 → address sequence 0,1,2,3,0,1… across frames; no done pulse.
- Stop and reset mid-clip:
  - play dropped mid-clip → at the next frame_start sample_out=0, state IDLE, no done pulse.
  - Reset_n=0 asserted in WAIT → all outputs are reset-valued on the next Clk.

Source files
------------

// File: rtl/audio_sample_feeder_if.sv
// Sample-feeder bus: playback controls, ROM read port and the frame word handed to the I2S transmitter.
// master = feeder side, slave = the surrounding system (ROM, controls, transmitter).
interface audio_sample_feeder_if #(
  parameter int ADDR_W = 16
);
  logic              play;
  logic              loop;
  logic [2:0]        volume;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [31:0]       sample_out;
  logic              sample_strobe;
  logic              busy;
  logic              done;

  modport master (
    input  play, loop, volume, rom_data,
    output rom_addr, sample_out, sample_strobe, busy, done
  );

  modport slave (
    output play, loop, volume, rom_data,
    input  rom_addr, sample_out, sample_strobe, busy, done
  );
endinterface

// File: rtl/audio_sample_feeder.sv
// Fetches 8-bit PCM from ROM and presents an LRCLK-aligned 32-bit I2S frame word with play/stop/loop control.
// Word lands ~3 Clk after each LRCLK fall; no backpressure, the transmitter must take one word per frame.
module audio_sample_feeder #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SAMPLE_LEN = 16'd44000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   LRCLK,
  audio_sample_feeder_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = SAMPLE_LEN - ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, LOAD} state_t;

  state_t             state;
  logic [1:0]         lr_sync;
  logic               lr_hist;
  logic               frame_start;
  logic [31:0]        prep_word;
  logic signed [7:0]  s8;
  logic signed [23:0] s24;

  // Falling LRCLK marks the start of the left channel.
  assign frame_start = ~lr_sync[1] & lr_hist;

  assign s8  = $signed(bus.rom_data ^ 8'h80);
  assign s24 = $signed({s8, 16'h0000}) >>> bus.volume;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state             <= IDLE;
      lr_sync           <= 2'b00;
      lr_hist           <= 1'b0;
      prep_word         <= '0;
      bus.rom_addr      <= '0;
      bus.sample_out    <= '0;
      bus.sample_strobe <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      lr_sync           <= {lr_sync[0], LRCLK};
      lr_hist           <= lr_sync[1];
      bus.sample_strobe <= 1'b0;
      bus.done          <= 1'b0;

      case (state)
        IDLE: begin
          // Silence from the first frame boundary after the clip ends or stops.
          if (frame_start) begin
            bus.sample_out <= '0;
            if (bus.play) begin
              bus.rom_addr <= '0;
              bus.busy     <= 1'b1;
              state        <= FETCH;
            end
          end
        end

        FETCH: state <= WAIT;

        WAIT: begin
          prep_word <= {1'b0, s24, 7'b0000000};
          state     <= LOAD;
        end

        LOAD: begin
          if (frame_start) begin
            bus.sample_strobe <= 1'b1;
            if (!bus.play) begin
              bus.sample_out <= '0;
              bus.busy       <= 1'b0;
              state          <= IDLE;
            end else begin
              bus.sample_out <= prep_word;
              if (bus.rom_addr == LAST_ADDR) begin
                if (bus.loop) begin
                  bus.rom_addr <= '0;
                  state        <= FETCH;
                end else begin
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
                end
              end else begin
                bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
                state        <= FETCH;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
